// File: rtl/csr_responder_pkg.sv
// Shared types and constants for the accelerator CSR endpoint.
package csr_responder_pkg;

    // Launch state machine: idle, waiting for the accelerator to take the start, running.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_e;

    // Internal registers follow directly after the accelerator status block.
    localparam int BUSY_OFS  = 0;
    localparam int PERF_OFS  = 1;

    // Bit of the start register that requests a launch.
    localparam int START_BIT = 0;

endpackage

// File: rtl/csr_rsp_reg.sv
// Single-entry read response holding register with valid/ready hand-off.
module csr_rsp_reg #(
    parameter int RegDataWidth = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [RegDataWidth-1:0] load_data,
    input  logic                    rsp_ready,
    output logic                    rsp_valid,
    output logic [RegDataWidth-1:0] rsp_data,
    output logic                    rsp_free
);

    logic                    rsp_vld_p1;
    logic [RegDataWidth-1:0] rsp_data_p1;

    // Capture a new response on load; hold data and valid until the core takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else if (load) begin
            rsp_vld_p1  <= 1'b1;
            rsp_data_p1 <= load_data;
        end else if (rsp_ready) begin
            rsp_vld_p1  <= 1'b0;
        end
    end

    // The slot can take a new entry when empty or being drained this cycle.
    assign rsp_free  = !rsp_vld_p1 || rsp_ready;
    assign rsp_valid = rsp_vld_p1;
    assign rsp_data  = rsp_data_p1;

endmodule

// File: rtl/csr_responder.sv
// Accelerator-side CSR endpoint: config bank, status readback, launch FSM and busy counter.
module csr_responder
    import csr_responder_pkg::*;
#(
    parameter int RegRWCount    = 8,
    parameter int RegROCount    = 2,
    parameter int RegDataWidth  = 32,
    parameter int TotalRegCount = RegRWCount + RegROCount + 2,
    parameter int RegAddrWidth  = $clog2(TotalRegCount)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [RegAddrWidth-1:0]                csr_addr_i,
    input  logic [RegDataWidth-1:0]                csr_wr_data_i,
    input  logic                                   csr_wr_en_i,
    input  logic                                   csr_req_valid_i,
    output logic                                   csr_req_ready_o,
    output logic [RegDataWidth-1:0]                csr_rd_data_o,
    output logic                                   csr_rsp_valid_o,
    input  logic                                   csr_rsp_ready_i,
    output logic [RegRWCount-1:0][RegDataWidth-1:0] register_rw_set_o,
    input  logic [RegROCount-1:0][RegDataWidth-1:0] register_ro_set_i,
    output logic                                   acc_start_valid_o,
    input  logic                                   acc_start_ready_i,
    input  logic                                   acc_done_i
);

    localparam logic [RegAddrWidth-1:0] RwEndAddr = RegAddrWidth'(RegRWCount);
    localparam logic [RegAddrWidth-1:0] StartAddr = RegAddrWidth'(RegRWCount - 1);
    localparam logic [RegAddrWidth-1:0] BusyAddr  = RegAddrWidth'(RegRWCount + RegROCount + BUSY_OFS);
    localparam logic [RegAddrWidth-1:0] PerfAddr  = RegAddrWidth'(RegRWCount + RegROCount + PERF_OFS);

    state_e                                  state_q;
    logic                                    start_vld_q;
    logic [RegRWCount-1:0][RegDataWidth-1:0] rw_q;
    logic [RegDataWidth-1:0]                 perf_q;
    logic [RegDataWidth-1:0]                 rd_mux;
    logic                                    rsp_free;
    logic                                    is_rw;
    logic                                    req_accept;
    logic                                    rw_wr;
    logic                                    rd_load;
    logic                                    launch;

    function automatic logic [RegDataWidth-1:0] sat_inc(input logic [RegDataWidth-1:0] v);
        return (v == '1) ? v : v + RegDataWidth'(1);
    endfunction

    assign is_rw           = csr_addr_i < RwEndAddr;
    // Config writes wait while the accelerator runs; reads only wait on the response slot.
    assign csr_req_ready_o = rsp_free && !(csr_wr_en_i && (state_q != IDLE) && is_rw);
    assign req_accept      = csr_req_valid_i && csr_req_ready_o;
    assign rw_wr           = req_accept && csr_wr_en_i && is_rw;
    assign rd_load         = req_accept && !csr_wr_en_i;
    assign launch          = rw_wr && (state_q == IDLE) && (csr_addr_i == StartAddr)
                             && csr_wr_data_i[START_BIT];

    // Read mux over the full map; unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < RegRWCount; i++) begin
            if (csr_addr_i == RegAddrWidth'(i)) rd_mux = rw_q[i];
        end
        for (int j = 0; j < RegROCount; j++) begin
            if (csr_addr_i == RegAddrWidth'(RegRWCount + j)) rd_mux = register_ro_set_i[j];
        end
        if (csr_addr_i == BusyAddr) rd_mux = {{(RegDataWidth-1){1'b0}}, state_q != IDLE};
        if (csr_addr_i == PerfAddr) rd_mux = perf_q;
    end

    // Config bank: CSR writes, plus self-clear of the start bit when the accelerator finishes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rw_q <= '0;
        end else begin
            if (rw_wr) begin
                for (int i = 0; i < RegRWCount; i++) begin
                    if (csr_addr_i == RegAddrWidth'(i)) rw_q[i] <= csr_wr_data_i;
                end
            end
            if ((state_q == BUSY) && acc_done_i) rw_q[RegRWCount-1][START_BIT] <= 1'b0;
        end
    end

    // Launch FSM with registered start-valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            start_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q     <= LAUNCH;
                        start_vld_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (acc_start_ready_i) begin
                        state_q     <= BUSY;
                        start_vld_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (acc_done_i) state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    start_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Busy-cycle counter: restarts at launch, counts LAUNCH and BUSY cycles, saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (launch) begin
            perf_q <= '0;
        end else if (state_q != IDLE) begin
            perf_q <= sat_inc(perf_q);
        end
    end

    csr_rsp_reg #(
        .RegDataWidth(RegDataWidth)
    ) u_rsp_reg (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (rd_load),
        .load_data(rd_mux),
        .rsp_ready(csr_rsp_ready_i),
        .rsp_valid(csr_rsp_valid_o),
        .rsp_data (csr_rd_data_o),
        .rsp_free (rsp_free)
    );

    assign register_rw_set_o = rw_q;
    assign acc_start_valid_o = start_vld_q;

endmodule

// File: tb/tb_csr_responder.sv
// Directed self-checking bench for csr_responder.
module tb_csr_responder;

    logic             clk;
    logic             rst_ni;
    logic [3:0]       csr_addr;
    logic [31:0]      csr_wr_data;
    logic             csr_wr_en;
    logic             csr_req_valid;
    logic             csr_req_ready;
    logic [31:0]      csr_rd_data;
    logic             csr_rsp_valid;
    logic             csr_rsp_ready;
    logic [7:0][31:0] rw_set;
    logic [1:0][31:0] ro_set;
    logic             acc_start_valid;
    logic             acc_start_ready;
    logic             acc_done;

    int n_checks = 0;
    int n_errors = 0;

    csr_responder dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .csr_addr_i       (csr_addr),
        .csr_wr_data_i    (csr_wr_data),
        .csr_wr_en_i      (csr_wr_en),
        .csr_req_valid_i  (csr_req_valid),
        .csr_req_ready_o  (csr_req_ready),
        .csr_rd_data_o    (csr_rd_data),
        .csr_rsp_valid_o  (csr_rsp_valid),
        .csr_rsp_ready_i  (csr_rsp_ready),
        .register_rw_set_o(rw_set),
        .register_ro_set_i(ro_set),
        .acc_start_valid_o(acc_start_valid),
        .acc_start_ready_i(acc_start_ready),
        .acc_done_i       (acc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_addr      = a;
        csr_wr_data   = d;
        csr_wr_en     = 1'b1;
        csr_req_valid = 1'b1;
        #1;
        for (int k = 0; k < 50 && !csr_req_ready; k++) @(negedge clk);
        check("wr_ready", {31'b0, csr_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        csr_wr_en     = 1'b0;
        @(negedge clk);
    endtask

    task automatic csr_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        csr_addr      = a;
        csr_wr_en     = 1'b0;
        csr_req_valid = 1'b1;
        #1;
        for (int k = 0; k < 50 && !csr_req_ready; k++) @(negedge clk);
        check({tag, "_ready"}, {31'b0, csr_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_vld"}, {31'b0, csr_rsp_valid}, 32'd1);
        check(tag, csr_rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni          = 1'b0;
        csr_addr        = '0;
        csr_wr_data     = '0;
        csr_wr_en       = 1'b0;
        csr_req_valid   = 1'b0;
        csr_rsp_ready   = 1'b1;
        acc_start_ready = 1'b0;
        acc_done        = 1'b0;
        ro_set[0]       = 32'h0000_0055;
        ro_set[1]       = 32'hA5A5_A5A5;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_vld", {31'b0, csr_rsp_valid}, 32'd0);
        check("rst_rd_data", csr_rd_data, 32'd0);
        check("rst_start_vld", {31'b0, acc_start_valid}, 32'd0);
        check("rst_rw3", rw_set[3], 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        csr_read(4'd10, 32'd0, "rst_busy");
        csr_read(4'd11, 32'd0, "rst_perf");

        // Write then read back
        csr_write(4'd3, 32'hDEAD_BEEF);
        check("wr_rw3", rw_set[3], 32'hDEAD_BEEF);
        check("wr_no_rsp", {31'b0, csr_rsp_valid}, 32'd0);
        csr_read(4'd3, 32'hDEAD_BEEF, "rd3");

        // Response held under backpressure, next read stalled
        csr_write(4'd1, 32'h1234_5678);
        csr_rsp_ready = 1'b0;
        csr_addr      = 4'd1;
        csr_req_valid = 1'b1;
        #1;
        check("hold_first_ready", {31'b0, csr_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        csr_addr = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_vld", {31'b0, csr_rsp_valid}, 32'd1);
            check("hold_data", csr_rd_data, 32'h1234_5678);
            check("hold_stall", {31'b0, csr_req_ready}, 32'd0);
        end
        csr_rsp_ready = 1'b1;
        #1;
        check("hold_release_ready", {31'b0, csr_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        @(negedge clk);
        check("b2b_vld", {31'b0, csr_rsp_valid}, 32'd1);
        check("b2b_data", csr_rd_data, 32'hDEAD_BEEF);

        // Launch with delayed start-ready
        csr_write(4'd7, 32'h0000_0001);
        check("launch_rw7", rw_set[7], 32'd1);
        check("launch_v1", {31'b0, acc_start_valid}, 32'd1);
        @(negedge clk);
        check("launch_v2", {31'b0, acc_start_valid}, 32'd1);
        @(negedge clk);
        check("launch_v3", {31'b0, acc_start_valid}, 32'd1);
        acc_start_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_start_ready = 1'b0;
        // BUSY cycle 1: config write must stall
        @(negedge clk);
        check("busy_start_vld", {31'b0, acc_start_valid}, 32'd0);
        csr_addr      = 4'd2;
        csr_wr_data   = 32'h0000_CAFE;
        csr_wr_en     = 1'b1;
        csr_req_valid = 1'b1;
        #1;
        check("busy_wr_stall1", {31'b0, csr_req_ready}, 32'd0);
        // BUSY cycle 2: still stalled, then switch to a status read
        @(negedge clk);
        check("busy_wr_stall2", {31'b0, csr_req_ready}, 32'd0);
        csr_wr_en = 1'b0;
        csr_addr  = 4'd8;
        #1;
        check("busy_rd_ready", {31'b0, csr_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        // BUSY cycle 3
        @(negedge clk);
        check("ro0_vld", {31'b0, csr_rsp_valid}, 32'd1);
        check("ro0_data", csr_rd_data, 32'h0000_0055);
        csr_addr      = 4'd10;
        csr_req_valid = 1'b1;
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
        // BUSY cycle 4
        @(negedge clk);
        check("busy_bit", csr_rd_data, 32'd1);
        repeat (6) @(negedge clk);
        // BUSY cycle 10: done arrives together with a BUSY read
        acc_done      = 1'b1;
        csr_addr      = 4'd10;
        csr_req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_done      = 1'b0;
        csr_req_valid = 1'b0;
        @(negedge clk);
        check("done_busy_pre", csr_rd_data, 32'd1);
        check("done_rw7_clr", rw_set[7], 32'd0);
        check("done_rw2_kept", rw_set[2], 32'd0);
        csr_read(4'd11, 32'd13, "perf13");
        csr_read(4'd10, 32'd0, "busy_idle");
        csr_read(4'd11, 32'd13, "perf_hold");

        // Start write without bit0, out-of-range read, dropped RO write
        csr_write(4'd7, 32'h0000_0006);
        check("nolaunch_rw7", rw_set[7], 32'h0000_0006);
        check("nolaunch_vld", {31'b0, acc_start_valid}, 32'd0);
        csr_read(4'd10, 32'd0, "nolaunch_busy");
        csr_read(4'd15, 32'd0, "oor15");
        csr_write(4'd9, 32'h1111_1111);
        check("ro_wr_no_rsp", {31'b0, csr_rsp_valid}, 32'd0);
        csr_read(4'd9, 32'hA5A5_A5A5, "ro1_unchanged");

        // Async reset mid-BUSY with a pending response
        csr_write(4'd5, 32'h0000_005A);
        csr_write(4'd7, 32'h0000_0003);
        check("l2_start_vld", {31'b0, acc_start_valid}, 32'd1);
        acc_start_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_start_ready = 1'b0;
        @(negedge clk);
        csr_rsp_ready = 1'b0;
        csr_read(4'd5, 32'h0000_005A, "pend_rd5");
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_rsp_vld", {31'b0, csr_rsp_valid}, 32'd0);
        check("arst_rd_data", csr_rd_data, 32'd0);
        check("arst_start_vld", {31'b0, acc_start_valid}, 32'd0);
        for (int i = 0; i < 8; i++) check("arst_rw", rw_set[i], 32'd0);
        @(negedge clk);
        rst_ni        = 1'b1;
        csr_rsp_ready = 1'b1;
        @(negedge clk);
        csr_read(4'd10, 32'd0, "arst_busy");
        csr_read(4'd11, 32'd0, "arst_perf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_responder.md
Name: csr_responder

Overview:
Accelerator-side CSR endpoint. It terminates the core's CSR request/response channel after address demuxing and holds a bank of read-write configuration registers. It also exposes accelerator read-only status registers, launches the accelerator with a valid/ready start handshake, and reports busy state and a busy-cycle counter. One instance sits behind each output port of the CSR demux.

Parameters:
RegRWCount, 8, number of read-write config registers (addresses 0..RegRWCount-1); the last one is the start register.
RegROCount, 2, number of accelerator read-only status registers (addresses RegRWCount..RegRWCount+RegROCount-1).
RegDataWidth, 32, CSR data width.
TotalRegCount, RegRWCount+RegROCount+2, total register count; includes the internal BUSY and PERF registers.
RegAddrWidth, $clog2(TotalRegCount), CSR address width.

Ports:
clk_i  in  1  clock; everything is rising-edge.
rst_ni  in  1  asynchronous active-low reset.
csr_addr_i  in  RegAddrWidth  request address, already offset-stripped.
csr_wr_data_i  in  RegDataWidth  write data.
csr_wr_en_i  in  1  1 = write, 0 = read.
csr_req_valid_i  in  1  request valid.
csr_req_ready_o  out  1  request accepted when valid&ready.
csr_rd_data_o  out  RegDataWidth  read response data.
csr_rsp_valid_o  out  1  read response valid.
csr_rsp_ready_i  in  1  core accepts response.
register_rw_set_o  out  RegRWCount x RegDataWidth  current config register contents.
register_ro_set_i  in  RegROCount x RegDataWidth  accelerator status values.
acc_start_valid_o  out  1  launch request to accelerator.
acc_start_ready_i  in  1  accelerator accepts launch.
acc_done_i  in  1  single-cycle pulse, accelerator finished.

Behaviour:
- Reset (asynchronous, rst_ni=0): all config registers 0, state IDLE, PERF 0. csr_rsp_valid_o=0, csr_rd_data_o=0, acc_start_valid_o=0. Reset mid-transaction drops any pending response and any launch.
- Address map:
  - RW at 0..RegRWCount-1.
  - RO at RegRWCount..RegRWCount+RegROCount-1.
  - BUSY at RegRWCount+RegROCount: bit0 = (state!=IDLE).
  - PERF at BUSY+1.
  - Reads of any address >= TotalRegCount return 0.
- Writes:
  - Accepted writes to RW addresses update the register on the next edge. No response is generated.
  - Writes to RO, BUSY, PERF or out-of-range addresses are accepted and dropped.
- Reads:
  - An accepted read registers its data and sets csr_rsp_valid_o on the next cycle (1-cycle latency).
  - Data and valid are held stable until csr_rsp_ready_i=1.
  - Read data is sampled at acceptance: the value before that edge's updates.
- csr_req_ready_o = rsp_free AND NOT (csr_wr_en_i AND state!=IDLE AND addr<RegRWCount).
  - rsp_free = !csr_rsp_valid_o || csr_rsp_ready_i, so back-to-back reads sustain 1 per cycle.
  - Config writes stall while the accelerator is active. Reads are never blocked by state.
- FSM IDLE -> LAUNCH -> BUSY -> IDLE:
  - IDLE: an accepted write to address RegRWCount-1 with wr_data[0]=1 stores the data and moves to LAUNCH. A write with bit0=0 only stores the data.
  - LAUNCH: acc_start_valid_o=1. On acc_start_ready_i=1, go to BUSY. acc_done_i is ignored in LAUNCH.
  - BUSY: on acc_done_i=1, go to IDLE and clear bit0 of the start register on the same edge.
- PERF:
  - Cleared on the IDLE->LAUNCH edge.
  - Increments every cycle state is LAUNCH or BUSY.
  - Saturates at all-ones and holds its value in IDLE.
- Simultaneous events: a read of BUSY accepted in the cycle acc_done_i arrives returns 1 (pre-edge value).

Decomposition:
- Shared package csr_responder_pkg:
  - state enum {IDLE, LAUNCH, BUSY};
  - localparams for BUSY/PERF address offsets;
  - start-bit index constant (0).
- One natural sub-module: csr_rsp_reg, the single-entry response holding register with valid/ready and the rsp_free signal.
- Address decode, register bank, FSM and counter stay in the top module.

Test Plan:
- Reset, then write addr 3 = 0xDEADBEEF, then read addr 3 -> register_rw_set_o[3]=0xDEADBEEF; response 0xDEADBEEF one cycle after acceptance.
- Read addr 1 with csr_rsp_ready_i=0 for 4 cycles -> rsp_valid and data held stable; req_ready=0 for a following read until the response is taken.
- Write addr 7 = 0x1 with acc_start_ready_i delayed 3 cycles, then acc_done_i after 10 BUSY cycles -> start_valid held 3 cycles; PERF reads 13 afterward; BUSY reads 0; register 7 bit0 = 0.
- While BUSY, write addr 2 -> req_ready=0 until done. Read addr 8 (RO[0] = 0x55) -> 0x55 returned with no stall.
- Write addr 7 = 0x0 in IDLE -> no launch, register stores 0. Read addr 15 (out-of-range) -> 0. Write addr 9 -> dropped, no response.
- Assert rst_ni=0 asynchronously mid-BUSY with a pending response -> start_valid, rsp_valid, PERF and all registers 0 immediately; state IDLE.
